// File: rtl/adc_spi_resp.sv
// -----------------------------------------------------------------------------
// adc_spi_resp
//
// Behavioural stand-in for the 8-channel, 12-bit IR-sensor ADC at the far end
// of the line-sensor SPI link. It answers the line-sensor initiator in place of
// the physical converter.
//
// Each 16-bit frame shifts out the conversion of the channel that was
// addressed in the *previous* frame. This matches the real ADC's pipelined
// addressing. Channel values are loaded by the bench or host through a simple
// write port.
//
// Optional build macro:
//   ADC_NOISE_EN - When defined, an 8-bit LFSR adds -4..+3 of noise to every
//                  loaded word, and the result is saturated to 0..2^DATA_W-1.
//                  When undefined, the returned words are exact.
//
// Ports:
//   clk        in   system clock (50 MHz)
//   rst_n      in   asynchronous active-low reset
//   SS_n       in   slave select from initiator, active low
//   SCLK       in   SPI clock from initiator, idles high
//   MOSI       in   command bits from initiator, sampled on SCLK rise
//   MISO       out  conversion bits to initiator, changes on SCLK fall
//   wr_en      in   channel-value write strobe
//   wr_ch      in   channel to write
//   wr_data    in   value to write
//   frame_done out  one-clk pulse per completed 16-bit frame
//   frame_cnt  out  completed-frame count, wraps
//   cur_ch     out  channel whose data the next frame returns
// -----------------------------------------------------------------------------
module adc_spi_resp #(
   parameter int                NUM_CH   = 8,
   parameter int                DATA_W   = 12,
   parameter int                ADDR_LSB = 11,
   parameter logic [DATA_W-1:0] RST_VAL  = 12'h800,
   parameter int                CH_W     = $clog2(NUM_CH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              SS_n,
   input  logic              SCLK,
   input  logic              MOSI,
   output logic              MISO,
   input  logic              wr_en,
   input  logic [CH_W-1:0]   wr_ch,
   input  logic [DATA_W-1:0] wr_data,
   output logic              frame_done,
   output logic [15:0]       frame_cnt,
   output logic [CH_W-1:0]   cur_ch
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // ---------------------------------------------------------------------------
   // Input synchronisers.
   // Bits [1:0] form the two-flop synchroniser; bit [2] is the edge-detect
   // history. SS_n and SCLK reset to their idle-high level, so that leaving
   // reset never looks like an edge.
   // ---------------------------------------------------------------------------
   logic [2:0] r_ss_sync;
   logic [2:0] r_sclk_sync;
   logic [1:0] r_mosi_sync;

   // Two-flop synchronisers plus edge-history flop for the SPI pins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ss_sync   <= 3'b111;
         r_sclk_sync <= 3'b111;
         r_mosi_sync <= 2'b00;
      end else begin
         r_ss_sync   <= {r_ss_sync[1:0], SS_n};
         r_sclk_sync <= {r_sclk_sync[1:0], SCLK};
         r_mosi_sync <= {r_mosi_sync[0], MOSI};
      end
   end

   logic w_ss_high;
   logic w_ss_fall;
   logic w_ss_rise;
   logic w_sclk_rise;
   logic w_sclk_fall;
   logic w_mosi;

   assign w_ss_high   = r_ss_sync[1];
   assign w_ss_fall   = r_ss_sync[2] & ~r_ss_sync[1];
   assign w_ss_rise   = ~r_ss_sync[2] & r_ss_sync[1];
   assign w_sclk_rise = ~r_sclk_sync[2] & r_sclk_sync[1];
   assign w_sclk_fall = r_sclk_sync[2] & ~r_sclk_sync[1];
   // MOSI has the same two-flop latency as SCLK, so it stays aligned with
   // the synced SCLK rise.
   assign w_mosi      = r_mosi_sync[1];

   // ---------------------------------------------------------------------------
   // Channel value registers.
   // ---------------------------------------------------------------------------
   logic [DATA_W-1:0] r_chan [NUM_CH];

   // Host-side write port into the channel registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            r_chan[i] <= RST_VAL;
         end
      end else if (wr_en) begin
         r_chan[wr_ch] <= wr_data;
      end else begin
         r_chan[wr_ch] <= r_chan[wr_ch];
      end
   end

   // ---------------------------------------------------------------------------
   // FSM registers.
   // ---------------------------------------------------------------------------
   state_t            r_state;
   logic              r_done_first;
   logic [15:0]       r_tx_shft;
   logic [15:0]       r_rx_shft;
   logic [4:0]        r_bit_cnt;
   logic              r_miso;
   logic              r_frame_done;
   logic [15:0]       r_frame_cnt;
   logic [CH_W-1:0]   r_cur_ch;
   logic [15:0]       w_load_word;

`ifdef ADC_NOISE_EN
   // ---------------------------------------------------------------------------
   // Noise source.
   // Fibonacci LFSR, x^8+x^6+x^5+x^4+1. It steps once per completed frame.
   // ---------------------------------------------------------------------------
   logic [7:0] r_lfsr;

   function automatic logic [7:0] f_lfsr_next(input logic [7:0] cur);
      return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
   endfunction

   // Add a signed 3-bit offset (-4..+3) and clamp to the converter range.
   // The sum is two bits wider than the data:
   //   - the top bit flags an underflow below zero;
   //   - the next bit flags an overflow past full scale.
   function automatic logic [DATA_W-1:0] f_noisy(input logic [DATA_W-1:0] d,
                                                 input logic [2:0]        n);
      logic [DATA_W+1:0] sum;
      sum = {2'b00, d} + {{(DATA_W-1){n[2]}}, n};
      if (sum[DATA_W+1]) begin
         return {DATA_W{1'b0}};
      end else if (sum[DATA_W]) begin
         return {DATA_W{1'b1}};
      end else begin
         return sum[DATA_W-1:0];
      end
   endfunction

   // LFSR advances on the first DONE cycle of each completed frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lfsr <= 8'hA5;
      end else if ((r_state == ST_DONE) && r_done_first) begin
         r_lfsr <= f_lfsr_next(r_lfsr);
      end else begin
         r_lfsr <= r_lfsr;
      end
   end

   // Word presented at frame start: noisy channel value, zero-padded to 16 bits
   always_comb begin
      w_load_word = {{(16-DATA_W){1'b0}}, f_noisy(r_chan[r_cur_ch], r_lfsr[2:0])};
   end
`else
   // Word presented at frame start: exact channel value, zero-padded to 16 bits.
   // A write landing on the same edge as the load is not yet visible here,
   // so a colliding write takes effect from the following frame.
   always_comb begin
      w_load_word = {{(16-DATA_W){1'b0}}, r_chan[r_cur_ch]};
   end
`endif

   // ---------------------------------------------------------------------------
   // Frame FSM.
   // MISO is registered: it is updated on the same edge that loads or shifts
   // tx_shft, so it always equals the bit the initiator should see next.
   // ---------------------------------------------------------------------------
   // Frame sequencing, shift registers and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_done_first <= 1'b0;
         r_tx_shft    <= 16'h0000;
         r_rx_shft    <= 16'h0000;
         r_bit_cnt    <= 5'd0;
         r_miso       <= 1'b0;
         r_frame_done <= 1'b0;
         r_frame_cnt  <= 16'h0000;
         r_cur_ch     <= {CH_W{1'b0}};
      end else begin
         r_frame_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_ss_fall) begin
                  r_tx_shft <= w_load_word;
                  r_rx_shft <= 16'h0000;
                  r_bit_cnt <= 5'd0;
                  r_miso    <= w_load_word[15];
                  r_state   <= ST_SHIFT;
               end else begin
                  r_miso    <= 1'b0;
               end
            end

            ST_SHIFT: begin
               // A full frame takes priority over a late deselect. Any other
               // deselect aborts without touching the address or the count.
               if (r_bit_cnt == 5'd16) begin
                  r_state      <= ST_DONE;
                  r_done_first <= 1'b1;
                  r_miso       <= 1'b0;
               end else if (w_ss_rise) begin
                  r_state      <= ST_IDLE;
                  r_miso       <= 1'b0;
               end else if (w_sclk_rise) begin
                  r_rx_shft    <= {r_rx_shft[14:0], w_mosi};
                  r_bit_cnt    <= r_bit_cnt + 5'd1;
               end else if (w_sclk_fall) begin
                  r_tx_shft    <= {r_tx_shft[14:0], 1'b0};
                  r_miso       <= r_tx_shft[14];
               end else begin
                  r_miso       <= r_tx_shft[15];
               end
            end

            ST_DONE: begin
               r_miso <= 1'b0;
               if (r_done_first) begin
                  r_done_first <= 1'b0;
                  r_cur_ch     <= r_rx_shft[ADDR_LSB +: CH_W];
                  r_frame_done <= 1'b1;
                  r_frame_cnt  <= r_frame_cnt + 16'd1;
               end else if (w_ss_high) begin
                  r_state      <= ST_IDLE;
               end else begin
                  r_state      <= ST_DONE;
               end
            end

            default: begin
               r_state      <= ST_IDLE;
               r_done_first <= 1'b0;
               r_miso       <= 1'b0;
            end
         endcase
      end
   end

   // Only the address field of the received word is consumed. The remaining
   // command bits are don't-care for this converter model.
   logic w_unused_rx;
   assign w_unused_rx = ^r_rx_shft;

   assign MISO       = r_miso;
   assign frame_done = r_frame_done;
   assign frame_cnt  = r_frame_cnt;
   assign cur_ch     = r_cur_ch;

endmodule

// File: tb/tb_adc_spi_resp.sv
// -----------------------------------------------------------------------------
// tb_adc_spi_resp
//
// Directed bench for adc_spi_resp. It acts as the SPI initiator:
//   - SCLK idles high;
//   - MOSI changes on SCLK fall;
//   - MISO is captured just before each SCLK fall.
//
// Build-dependent behaviour:
//   - Default build: exact returned words are checked.
//   - With ADC_NOISE_EN: the bench keeps its own LFSR model, and checks both
//     the exact noisy words and the saturation bounds.
// -----------------------------------------------------------------------------
module tb_adc_spi_resp;

   localparam int HALF = 6;   // SCLK half period in clk cycles
   localparam int GAP  = 8;   // SS_n high time between frames

   logic        clk = 1'b0;
   logic        rst_n;
   logic        SS_n;
   logic        SCLK;
   logic        MOSI;
   logic        MISO;
   logic        wr_en;
   logic [2:0]  wr_ch;
   logic [11:0] wr_data;
   logic        frame_done;
   logic [15:0] frame_cnt;
   logic [2:0]  cur_ch;

   int n_chk = 0;
   int n_bad = 0;
   int done_cnt = 0;

   int          chan_m [8];
   int          cur_m;
   int          cnt_m;
   int          d0;
   logic [15:0] w;

   always #5 clk = ~clk;

   adc_spi_resp dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .SS_n       (SS_n),
      .SCLK       (SCLK),
      .MOSI       (MOSI),
      .MISO       (MISO),
      .wr_en      (wr_en),
      .wr_ch      (wr_ch),
      .wr_data    (wr_data),
      .frame_done (frame_done),
      .frame_cnt  (frame_cnt),
      .cur_ch     (cur_ch)
   );

   // Count frame_done pulses
   always @(posedge clk) begin
      if (frame_done === 1'b1) done_cnt <= done_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [2:0] ch, input logic [11:0] d);
      wr_en = 1'b1; wr_ch = ch; wr_data = d;
      wait_clk(1);
      wr_en = 1'b0;
   endtask

   // One SPI transaction with n_rise SCLK rises. When coll is set, a write
   // is placed on the clk edge at which the responder loads its word.
   task automatic spi_frame(input logic [15:0] mosi_w, input int n_rise,
                            input logic coll, input logic [2:0] coll_ch,
                            input logic [11:0] coll_d, output logic [15:0] miso_w);
      miso_w = 16'h0000;
      SS_n = 1'b0;
      if (coll) begin
         wait_clk(2);
         wr_en = 1'b1; wr_ch = coll_ch; wr_data = coll_d;
         wait_clk(1);
         wr_en = 1'b0;
         wait_clk(HALF - 3);
      end else begin
         wait_clk(HALF);
      end
      for (int i = 0; i < n_rise; i++) begin
         miso_w = {miso_w[14:0], MISO};
         SCLK = 1'b0;
         MOSI = mosi_w[15-i];
         wait_clk(HALF);
         SCLK = 1'b1;
         wait_clk(HALF);
      end
      SS_n = 1'b1;
      MOSI = 1'b0;
      wait_clk(GAP);
   endtask

`ifdef ADC_NOISE_EN
   function automatic int exp_noisy(input int d, input logic [7:0] l);
      int s;
      s = int'(l[2:0]);
      if (l[2]) s = s - 8;
      s = d + s;
      if (s < 0) s = 0;
      if (s > 4095) s = 4095;
      return s;
   endfunction
`endif

   initial begin
      rst_n = 1'b0; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
      wr_en = 1'b0; wr_ch = 3'd0; wr_data = 12'h000;
      for (int i = 0; i < 8; i++) chan_m[i] = 32'h800;
      cur_m = 0; cnt_m = 0;
      wait_clk(3);
      rst_n = 1'b1;
      wait_clk(2);

      chk("rst_miso", {31'd0, MISO}, 32'd0);
      chk("rst_done", {31'd0, frame_done}, 32'd0);
      chk("rst_cnt", {16'd0, frame_cnt}, 32'd0);
      chk("rst_cur", {29'd0, cur_ch}, 32'd0);

`ifdef ADC_NOISE_EN
      begin
         logic [7:0]  lfsr_m;
         logic [15:0] m;
         int          a;
         int          e;
         lfsr_m = 8'hA5;
         wr(3'd0, 12'h000); chan_m[0] = 0;
         wr(3'd1, 12'hFFF); chan_m[1] = 4095;
         wr(3'd2, 12'h400); chan_m[2] = 32'h400;
         for (int j = 0; j < 12; j++) begin
            a = (j + 1) % 3;
            m = 16'(a) << 11;
            spi_frame(m, 16, 1'b0, 3'd0, 12'h000, w);
            e = exp_noisy(chan_m[cur_m], lfsr_m);
            chk("noise_word", {16'd0, w}, e);
            if (cur_m == 0) chk("noise_lo_range", {31'd0, w <= 16'd3}, 32'd1);
            if (cur_m == 1) chk("noise_hi_range", {31'd0, (w >= 16'd4091) && (w <= 16'd4095)}, 32'd1);
            lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
            cur_m = a;
            cnt_m++;
         end
         chk("noise_cnt", {16'd0, frame_cnt}, cnt_m);
         chk("noise_cur", {29'd0, cur_ch}, cur_m);
      end
`else
      // Reset values, address 0
      d0 = done_cnt;
      spi_frame(16'h0000, 16, 1'b0, 3'd0, 12'h000, w);
      chk("t1_miso", {16'd0, w}, 32'h0800);
      chk("t1_done", done_cnt - d0, 32'd1);
      chk("t1_cnt", {16'd0, frame_cnt}, 32'd1);
      chk("t1_cur", {29'd0, cur_ch}, 32'd0);
      cnt_m = 1;

      // Pipelined addressing
      wr(3'd3, 12'hABC); chan_m[3] = 32'hABC;
      spi_frame(16'h1800, 16, 1'b0, 3'd0, 12'h000, w);
      chk("t2_f1_miso", {16'd0, w}, 32'h0800);
      chk("t2_f1_cur", {29'd0, cur_ch}, 32'd3);
      spi_frame(16'h0000, 16, 1'b0, 3'd0, 12'h000, w);
      chk("t2_f2_miso", {16'd0, w}, 32'h0ABC);
      chk("t2_f2_cur", {29'd0, cur_ch}, 32'd0);
      cnt_m += 2; cur_m = 0;

      // Address sweep over all channels
      for (int i = 0; i < 8; i++) begin
         wr(3'(i), 12'(32'h100 * i + i));
         chan_m[i] = 32'h100 * i + i;
      end
      d0 = done_cnt;
      for (int k = 0; k < 9; k++) begin
         int a;
         a = (k < 8) ? k : 5;
         spi_frame(16'(a) << 11, 16, 1'b0, 3'd0, 12'h000, w);
         chk("sweep_miso", {16'd0, w}, chan_m[cur_m]);
         cur_m = a;
         cnt_m++;
      end
      chk("sweep_ch7", {16'd0, w}, 32'h0707);
      chk("sweep_done", done_cnt - d0, 32'd9);
      chk("sweep_cur", {29'd0, cur_ch}, cur_m);

      // Aborted frame after 9 SCLKs
      d0 = done_cnt;
      spi_frame(16'h3800, 9, 1'b0, 3'd0, 12'h000, w);
      chk("abort_done", done_cnt - d0, 32'd0);
      chk("abort_cnt", {16'd0, frame_cnt}, cnt_m);
      chk("abort_cur", {29'd0, cur_ch}, 32'd5);
      spi_frame(16'h1000, 16, 1'b0, 3'd0, 12'h000, w);
      chk("abort_next", {16'd0, w}, 32'h0505);
      cur_m = 2; cnt_m++;

      // Write to cur_ch on the load edge: old value goes out
      spi_frame(16'h1000, 16, 1'b1, 3'd2, 12'h0EE, w);
      chk("coll_old", {16'd0, w}, 32'h0202);
      chan_m[2] = 32'h0EE; cnt_m++;
      spi_frame(16'h0000, 16, 1'b0, 3'd0, 12'h000, w);
      chk("coll_new", {16'd0, w}, 32'h00EE);
      cur_m = 0; cnt_m++;
      chk("cnt_track", {16'd0, frame_cnt}, cnt_m);

      // frame_cnt wrap
      force dut.r_frame_cnt = 16'hFFFF;
      wait_clk(1);
      release dut.r_frame_cnt;
      wait_clk(1);
      chk("wrap_pre", {16'd0, frame_cnt}, 32'hFFFF);
      d0 = done_cnt;
      spi_frame(16'h0000, 16, 1'b0, 3'd0, 12'h000, w);
      chk("wrap_cnt", {16'd0, frame_cnt}, 32'h0000);
      chk("wrap_done", done_cnt - d0, 32'd1);
`endif

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/adc_spi_resp.md
Name: adc_spi_resp

Overview:
SPI responder modelling the 8-channel, 12-bit IR-sensor ADC that sits at the far end of the SS_n/SCLK/MOSI/MISO link driven by the IR line-sensor interface. It answers the line-sensor SPI initiator and is used in the fullchip bench in place of the physical ADC. The bench or host loads channel values through a write port. Each 16-bit frame returns the conversion for the channel addressed in the previous frame, matching the ADC's pipelined addressing.

Parameters:
NUM_CH, 8, number of channels; channel address is clog2(NUM_CH) bits wide.
DATA_W, 12, conversion width; MISO word is {(16-DATA_W) zeros, data}.
ADDR_LSB, 11, LSB position of the channel address within the 16-bit MOSI word (address is MOSI word bits [13:11]).
RST_VAL, 12'h800, reset value of every channel register.

Ports:
clk  in  1  system clock, 50MHz
rst_n  in  1  asynchronous active-low reset
SS_n  in  1  slave select from initiator, active low
SCLK  in  1  SPI clock from initiator, idles high
MOSI  in  1  command data from initiator
MISO  out  1  conversion data to initiator
wr_en  in  1  channel-value write strobe
wr_ch  in  3  channel to write
wr_data  in  12  value to write
frame_done  out  1  one-clk pulse per completed 16-bit frame
frame_cnt  out  16  count of completed frames, wraps
cur_ch  out  3  channel whose data the next frame returns

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low (rst_n). Reset clears all state.
- Input synchronisation:
  - SS_n, SCLK and MOSI each pass through 2 flops, plus a third flop for edge detection.
  - Edges are seen 3 clk after the pin change.
  - Requirement: SCLK high and low phases must each be at least 4 clk.
- Reset values:
  - MISO=0, frame_done=0, frame_cnt=0, cur_ch=0.
  - All channel registers = RST_VAL.
  - FSM in IDLE.
- Channel registers:
  - On wr_en, write wr_data into chan[wr_ch] on the next edge.
  - A write during a frame does not affect the word already loaded for that frame.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: MISO=0. On synced SS_n fall:
    - load tx_shft = {4'b0, chan[cur_ch]}
    - clear bit_cnt and rx_shft
    - go to SHIFT.
  - SHIFT:
    - MISO = tx_shft[15].
    - On synced SCLK rise: rx_shft = {rx_shft[14:0], MOSI_sync}; bit_cnt++.
    - On synced SCLK fall: tx_shft <<= 1, unless bit_cnt==16.
    - When bit_cnt reaches 16: go to DONE.
  - DONE:
    - Single cycle: cur_ch <= rx_shft[13:11]; frame_done=1; frame_cnt++.
    - Then wait in DONE (MISO=0) until synced SS_n high, then go to IDLE.
    - Back-to-back frames therefore need SS_n high for at least 3 clk.
- Abort:
  - SS_n rise while in SHIFT: return to IDLE.
  - cur_ch, frame_cnt and frame_done are unchanged.
  - A partial frame never changes the address.
- SCLK edges while SS_n is high are ignored.
- frame_cnt wraps from 16'hFFFF to 0.
- Write collision: a wr_en to chan[cur_ch] in the same cycle as an SS_n fall is detected. The old value is loaded (write lands one cycle late relative to the load).
- Asserting rst_n low mid-frame: all state resets immediately; MISO goes to 0.

Optional Feature:
ADC_NOISE_EN.
- Defined:
  - An 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5 on reset) advances once per DONE.
  - The loaded word is chan[cur_ch] + sign-extended LFSR[2:0] (range -4..+3), saturated to 0..4095.
- Not defined: the loaded word is exact; no LFSR logic is present.
- The bench must run both builds.

Test Plan:
- Reset, no writes; frame with MOSI=16'h0000 -> MISO returns 16'h0800; frame_done pulses once; frame_cnt=1; cur_ch=0.
- Write chan[3]=12'hABC; frame1 MOSI=16'h1800 -> frame1 returns chan0=16'h0800 and cur_ch becomes 3; frame2 -> MISO returns 16'h0ABC.
- Write all 8 channels with 12'h100*i+i; sweep addresses 0..7 over 9 frames -> each frame returns the previous address's value; channel 7 returns 16'h0707.
- Raise SS_n after 9 SCLKs of a frame with MOSI=16'h3800 -> no frame_done; frame_cnt and cur_ch unchanged; the next full frame returns the old channel.
- Preload frame_cnt to 16'hFFFF via 65535 short frames (or force) and run one frame -> frame_cnt=0; frame_done still pulses.
- ADC_NOISE_EN defined, chan0=12'h000 and chan1=12'hFFF -> returned values stay within 0..3 and 4091..4095 respectively; never wrap.
